// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address receiver with per-bank state tracking.
// Decodes one command per clock from cs_n/act_n/A/bg/ba, checks it against the
// addressed bank's state and tRCD/tRP timers, and reports it as a legal command
// or as a rejected one.
// Optional feature macro: DDR4_CA_PARITY_EN (even C/A parity check).
// Bank state encoding on dbg_bank_state (2 bits per bank, bank b at [2b+1:2b]):
//   0 IDLE, 1 ACTIVATING, 2 ACTIVE, 3 PRECHARGING.
// Output strobes: cmd_valid and err_valid are single-cycle pulses, never both
// high; there is no back-pressure, every sampled command is consumed the cycle
// it is seen. Outputs reflect the pins sampled at the previous rising edge.
module ddr4_cmd_decoder #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 19,
  parameter int TRP       = 19,
  localparam int BKW      = BGWIDTH + BAWIDTH,
  localparam int NB       = 2 ** BKW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic                 parity,
  output logic                 cmd_valid,
  output logic [2:0]           cmd,
  output logic [BKW-1:0]       cmd_bank,
  output logic [ADDRWIDTH-1:0] cmd_row,
  output logic [COLWIDTH-1:0]  cmd_col,
  output logic                 cmd_ap,
  output logic                 cmd_bc_n,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [NB-1:0]        bank_open,
  output logic [NB-1:0]        bank_busy,
  output logic [2*NB-1:0]      dbg_bank_state
);

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [2:0] C_ACT  = 3'd0;
  localparam logic [2:0] C_RD   = 3'd1;
  localparam logic [2:0] C_WR   = 3'd2;
  localparam logic [2:0] C_PRE  = 3'd3;
  localparam logic [2:0] C_PREA = 3'd4;
  localparam logic [2:0] C_REF  = 3'd5;
  localparam logic [2:0] C_MRS  = 3'd6;
  localparam logic [2:0] C_ZQC  = 3'd7;

  localparam logic [1:0] E_STATE  = 2'd1;
  localparam logic [1:0] E_TIMING = 2'd2;
  localparam logic [1:0] E_PARITY = 2'd3;

  typedef enum logic [1:0] {
    B_IDLE        = 2'd0,
    B_ACTIVATING  = 2'd1,
    B_ACTIVE      = 2'd2,
    B_PRECHARGING = 2'd3
  } bank_state_t;

  bank_state_t          state_q [NB];
  bank_state_t          state_d [NB];
  logic [TW-1:0]        timer_q [NB];
  logic [TW-1:0]        timer_d [NB];

  logic                 is_cmd;
  logic [2:0]           dec;
  logic                 parity_bad;
  logic                 any_open;
  logic                 any_busy;
  logic [BKW-1:0]       bank_idx;
  logic [1:0]           err_d;
  logic                 cmd_valid_d;
  logic [2:0]           cmd_d;
  logic [BKW-1:0]       cmd_bank_d;
  logic [ADDRWIDTH-1:0] cmd_row_d;
  logic [COLWIDTH-1:0]  cmd_col_d;
  logic                 cmd_ap_d;
  logic                 cmd_bc_n_d;

  assign bank_idx = {bg, ba};

`ifdef DDR4_CA_PARITY_EN
  // Even parity: all checked pins including the parity pin must XOR to zero.
  assign parity_bad = ^{act_n, A, bg, ba, parity};
`else
  logic unused_parity;
  assign unused_parity = parity;
  assign parity_bad    = 1'b0;
`endif

  // Truth-table decode of the sampled pins; DES and NOP leave is_cmd low.
  always_comb begin
    is_cmd = 1'b0;
    dec    = C_ACT;
    if (cke && !cs_n) begin
      if (!act_n) begin
        is_cmd = 1'b1;
        dec    = C_ACT;
      end else begin
        case (A[16:14])
          3'b000:  begin is_cmd = 1'b1; dec = C_MRS; end
          3'b001:  begin is_cmd = 1'b1; dec = C_REF; end
          3'b010:  begin is_cmd = 1'b1; dec = A[10] ? C_PREA : C_PRE; end
          3'b100:  begin is_cmd = 1'b1; dec = C_WR; end
          3'b101:  begin is_cmd = 1'b1; dec = C_RD; end
          3'b110:  begin is_cmd = 1'b1; dec = C_ZQC; end
          default: begin is_cmd = 1'b0; dec = C_ACT; end
        endcase
      end
    end
  end

  // Next bank state: timers expire first, then the command is checked against
  // the post-expiry state so a command landing exactly on expiry is legal.
  always_comb begin
    any_open    = 1'b0;
    any_busy    = 1'b0;
    err_d       = 2'd0;
    cmd_valid_d = 1'b0;
    cmd_d       = 3'd0;
    cmd_bank_d  = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    cmd_ap_d    = 1'b0;
    cmd_bc_n_d  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      timer_d[b] = timer_q[b];
      if (state_q[b] == B_ACTIVATING || state_q[b] == B_PRECHARGING) begin
        if (timer_q[b] == '0) begin
          state_d[b] = (state_q[b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
        end else begin
          timer_d[b] = timer_q[b] - 1'b1;
        end
      end
      if (state_d[b] == B_ACTIVE || state_d[b] == B_ACTIVATING) any_open = 1'b1;
      if (state_d[b] == B_ACTIVATING || state_d[b] == B_PRECHARGING) any_busy = 1'b1;
    end

    if (is_cmd) begin
      if (parity_bad) begin
        err_d = E_PARITY;
      end else begin
        case (dec)
          C_ACT: begin
            if (state_d[bank_idx] == B_ACTIVE || state_d[bank_idx] == B_ACTIVATING)
              err_d = E_STATE;
            else if (state_d[bank_idx] == B_PRECHARGING)
              err_d = E_TIMING;
            else begin
              state_d[bank_idx] = B_ACTIVATING;
              timer_d[bank_idx] = TW'(TRCD - 1);
            end
          end
          C_RD, C_WR: begin
            if (state_d[bank_idx] == B_IDLE || state_d[bank_idx] == B_PRECHARGING)
              err_d = E_STATE;
            else if (state_d[bank_idx] == B_ACTIVATING)
              err_d = E_TIMING;
            else if (A[10]) begin
              state_d[bank_idx] = B_PRECHARGING;
              timer_d[bank_idx] = TW'(TRP - 1);
            end
          end
          C_PRE: begin
            if (state_d[bank_idx] == B_ACTIVATING)
              err_d = E_TIMING;
            else if (state_d[bank_idx] == B_ACTIVE) begin
              state_d[bank_idx] = B_PRECHARGING;
              timer_d[bank_idx] = TW'(TRP - 1);
            end
          end
          C_PREA: begin
            for (int b = 0; b < NB; b++) begin
              if (state_d[b] == B_ACTIVE) begin
                state_d[b] = B_PRECHARGING;
                timer_d[b] = TW'(TRP - 1);
              end
            end
          end
          default: begin
            if (any_open || any_busy) err_d = E_STATE;
          end
        endcase
      end

      if (err_d == 2'd0) begin
        cmd_valid_d = 1'b1;
        cmd_d       = dec;
        cmd_bank_d  = bank_idx;
        if (dec == C_ACT) cmd_row_d = A;
        if (dec == C_RD || dec == C_WR) begin
          cmd_col_d  = A[COLWIDTH-1:0];
          cmd_ap_d   = A[10];
          cmd_bc_n_d = A[12];
        end
      end
    end
  end

  // Registered command outputs and bank state; reset aborts all timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd       <= 3'd0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cmd_ap    <= 1'b0;
      cmd_bc_n  <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= B_IDLE;
        timer_q[b] <= '0;
      end
    end else begin
      cmd_valid <= cmd_valid_d;
      cmd       <= cmd_d;
      cmd_bank  <= cmd_bank_d;
      cmd_row   <= cmd_row_d;
      cmd_col   <= cmd_col_d;
      cmd_ap    <= cmd_ap_d;
      cmd_bc_n  <= cmd_bc_n_d;
      err_valid <= (err_d != 2'd0);
      err_code  <= err_d;
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        timer_q[b] <= timer_d[b];
      end
    end
  end

  // Per-bank status vectors derived from the registered bank state.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      bank_open[b]             = (state_q[b] == B_ACTIVE) || (state_q[b] == B_ACTIVATING);
      bank_busy[b]             = (state_q[b] == B_ACTIVATING) || (state_q[b] == B_PRECHARGING);
      dbg_bank_state[2*b +: 2] = state_q[b];
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed bench for ddr4_cmd_decoder with short tRCD/tRP so boundaries are quick.
module tb_ddr4_cmd_decoder;

  localparam int TRCD = 5;
  localparam int TRP  = 4;

  logic        clk;
  logic        rst;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic [16:0] A;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic        parity;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [3:0]  cmd_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_ap;
  logic        cmd_bc_n;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] bank_open;
  logic [15:0] bank_busy;
  logic [31:0] dbg_bank_state;

  int total = 0;
  int bad   = 0;

  ddr4_cmd_decoder #(.TRCD(TRCD), .TRP(TRP)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A),
    .bg(bg), .ba(ba), .parity(parity), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
    .cmd_bc_n(cmd_bc_n), .err_valid(err_valid), .err_code(err_code),
    .bank_open(bank_open), .bank_busy(bank_busy), .dbg_bank_state(dbg_bank_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c_n, input logic a_n, input logic [16:0] addr,
                       input logic [3:0] bank, input logic flip);
    cke    = 1'b1;
    cs_n   = c_n;
    act_n  = a_n;
    A      = addr;
    bg     = bank[3:2];
    ba     = bank[1:0];
    parity = (^{a_n, addr, bank}) ^ flip;
  endtask

  task automatic des();
    drive(1'b1, 1'b1, 17'h0, 4'h0, 1'b0);
  endtask

  task automatic act(input logic [3:0] bank, input logic [16:0] row);
    drive(1'b0, 1'b0, row, bank, 1'b0);
  endtask

  task automatic cmd_pins(input logic [16:0] addr, input logic [3:0] bank);
    drive(1'b0, 1'b1, addr, bank, 1'b0);
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    act(4'h1, 17'h1);
    tick();
    tick();
    total++; if (cmd_valid !== 1'b0 || err_valid !== 1'b0) begin bad++;
      $display("FAIL reset_strobes got=%b%b exp=00", cmd_valid, err_valid); end
    total++; if (bank_open !== 16'h0 || bank_busy !== 16'h0) begin bad++;
      $display("FAIL reset_banks open=%h busy=%h exp=0", bank_open, bank_busy); end
    total++; if (cmd !== 3'd0 || cmd_row !== 17'h0 || err_code !== 2'd0) begin bad++;
      $display("FAIL reset_fields cmd=%0d row=%h err=%0d exp=0", cmd, cmd_row, err_code); end
    des();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_act_all();
    for (int i = 0; i < 16; i++) begin
      act(i[3:0], 17'h1);
      tick();
      total++; if (cmd_valid !== 1'b1 || cmd !== 3'd0) begin bad++;
        $display("FAIL act_strobe[%0d] valid=%b cmd=%0d exp=1/0", i, cmd_valid, cmd); end
      total++; if (cmd_row !== 17'h1 || cmd_bank !== i[3:0]) begin bad++;
        $display("FAIL act_fields[%0d] row=%h bank=%0d exp=1/%0d", i, cmd_row, cmd_bank, i); end
    end
    total++; if (bank_open !== 16'hFFFF) begin bad++;
      $display("FAIL act_all_open got=%h exp=ffff", bank_open); end
    total++; if (bank_busy !== 16'hF800) begin bad++;
      $display("FAIL act_all_busy got=%h exp=f800", bank_busy); end
    des();
    repeat (TRCD - 1) tick();
    total++; if (bank_busy !== 16'h8000 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL act_last_busy busy=%h valid=%b exp=8000/0", bank_busy, cmd_valid); end
    tick();
    total++; if (bank_busy !== 16'h0 || bank_open !== 16'hFFFF) begin bad++;
      $display("FAIL act_all_active busy=%h open=%h exp=0/ffff", bank_busy, bank_open); end
  endtask

  task automatic test_prea();
    cmd_pins(17'h08400, 4'h0);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin bad++;
      $display("FAIL prea_cmd valid=%b cmd=%0d exp=1/4", cmd_valid, cmd); end
    total++; if (bank_busy !== 16'hFFFF || bank_open !== 16'h0) begin bad++;
      $display("FAIL prea_banks busy=%h open=%h exp=ffff/0", bank_busy, bank_open); end
    des();
    repeat (TRP - 1) tick();
    total++; if (bank_busy !== 16'hFFFF) begin bad++;
      $display("FAIL prea_trp_edge got=%h exp=ffff", bank_busy); end
    tick();
    total++; if (bank_busy !== 16'h0) begin bad++;
      $display("FAIL prea_idle got=%h exp=0", bank_busy); end
  endtask

  task automatic test_rd_timing();
    act(4'h0, 17'h7);
    tick();
    total++; if (dbg_bank_state[1:0] !== 2'd1) begin bad++;
      $display("FAIL rd_activating got=%0d exp=1", dbg_bank_state[1:0]); end
    des();
    repeat (TRCD - 2) tick();
    cmd_pins(17'h14405, 4'h0);
    tick();
    total++; if (err_valid !== 1'b1 || err_code !== 2'd2 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL rd_early err=%b code=%0d valid=%b exp=1/2/0", err_valid, err_code, cmd_valid); end
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd1 || err_valid !== 1'b0) begin bad++;
      $display("FAIL rd_ontime valid=%b cmd=%0d err=%b exp=1/1/0", cmd_valid, cmd, err_valid); end
    total++; if (cmd_col !== 10'd5 || cmd_ap !== 1'b1 || cmd_bc_n !== 1'b0 || cmd_row !== 17'h0) begin bad++;
      $display("FAIL rd_fields col=%0d ap=%b bc_n=%b row=%h exp=5/1/0/0", cmd_col, cmd_ap, cmd_bc_n, cmd_row); end
    total++; if (dbg_bank_state[1:0] !== 2'd3 || bank_busy[0] !== 1'b1) begin bad++;
      $display("FAIL rd_ap_precharge st=%0d busy=%b exp=3/1", dbg_bank_state[1:0], bank_busy[0]); end
    des();
    repeat (TRP - 1) tick();
    total++; if (bank_busy[0] !== 1'b1) begin bad++;
      $display("FAIL rd_trp_edge got=%b exp=1", bank_busy[0]); end
    tick();
    total++; if (dbg_bank_state[1:0] !== 2'd0 || bank_busy !== 16'h0) begin bad++;
      $display("FAIL rd_idle st=%0d busy=%h exp=0/0", dbg_bank_state[1:0], bank_busy); end
  endtask

  task automatic test_back_to_back();
    act(4'h3, 17'h1ABCD);
    tick();
    total++; if (cmd_row !== 17'h1ABCD || cmd_bank !== 4'h3) begin bad++;
      $display("FAIL b2b_act row=%h bank=%0d exp=1abcd/3", cmd_row, cmd_bank); end
    des();
    repeat (TRCD - 1) tick();
    cmd_pins(17'h11003, 4'h3);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd2 || cmd_col !== 10'd3) begin bad++;
      $display("FAIL b2b_wr valid=%b cmd=%0d col=%0d exp=1/2/3", cmd_valid, cmd, cmd_col); end
    total++; if (cmd_ap !== 1'b0 || cmd_bc_n !== 1'b1 || bank_open !== 16'h0008 || bank_busy !== 16'h0) begin bad++;
      $display("FAIL b2b_wr_state ap=%b bc_n=%b open=%h busy=%h exp=0/1/0008/0", cmd_ap, cmd_bc_n, bank_open, bank_busy); end
    cmd_pins(17'h08000, 4'h3);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd3 || cmd_col !== 10'd0 || bank_busy !== 16'h0008) begin bad++;
      $display("FAIL b2b_pre valid=%b cmd=%0d col=%0d busy=%h exp=1/3/0/0008", cmd_valid, cmd, cmd_col, bank_busy); end
    act(4'h3, 17'h2);
    tick();
    total++; if (err_valid !== 1'b1 || err_code !== 2'd2 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL b2b_act_prech err=%b code=%0d valid=%b exp=1/2/0", err_valid, err_code, cmd_valid); end
    des();
    repeat (TRP - 3) tick();
    act(4'h3, 17'h2);
    tick();
    total++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin bad++;
      $display("FAIL b2b_trp_early err=%b code=%0d exp=1/2", err_valid, err_code); end
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd0 || cmd_row !== 17'h2) begin bad++;
      $display("FAIL b2b_trp_ontime valid=%b cmd=%0d row=%h exp=1/0/2", cmd_valid, cmd, cmd_row); end
    des();
    repeat (TRCD) tick();
    cmd_pins(17'h08000, 4'h3);
    tick();
    des();
    repeat (TRP) tick();
  endtask

  task automatic test_ref();
    act(4'h5, 17'h9);
    tick();
    des();
    repeat (TRCD) tick();
    cmd_pins(17'h04000, 4'h0);
    tick();
    total++; if (err_valid !== 1'b1 || err_code !== 2'd1 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL ref_open err=%b code=%0d valid=%b exp=1/1/0", err_valid, err_code, cmd_valid); end
    total++; if (bank_open !== 16'h0020 || bank_busy !== 16'h0) begin bad++;
      $display("FAIL ref_nochange open=%h busy=%h exp=0020/0", bank_open, bank_busy); end
    cmd_pins(17'h08000, 4'h5);
    tick();
    des();
    repeat (TRP) tick();
    cmd_pins(17'h04000, 4'h0);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd5 || err_valid !== 1'b0) begin bad++;
      $display("FAIL ref_idle valid=%b cmd=%0d err=%b exp=1/5/0", cmd_valid, cmd, err_valid); end
    cmd_pins(17'h00000, 4'h0);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd6) begin bad++;
      $display("FAIL mrs valid=%b cmd=%0d exp=1/6", cmd_valid, cmd); end
    cmd_pins(17'h18000, 4'h0);
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd !== 3'd7) begin bad++;
      $display("FAIL zqc valid=%b cmd=%0d exp=1/7", cmd_valid, cmd); end
    cmd_pins(17'h1C000, 4'h0);
    tick();
    total++; if (cmd_valid !== 1'b0 || err_valid !== 1'b0) begin bad++;
      $display("FAIL nop valid=%b err=%b exp=0/0", cmd_valid, err_valid); end
  endtask

  task automatic test_misc();
    act(4'h2, 17'h4);
    tick();
    des();
    repeat (TRCD) tick();
    act(4'h2, 17'h4);
    tick();
    total++; if (err_valid !== 1'b1 || err_code !== 2'd1 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL act_active err=%b code=%0d valid=%b exp=1/1/0", err_valid, err_code, cmd_valid); end
    drive(1'b1, 1'b0, 17'h4, 4'h6, 1'b0);
    tick();
    total++; if (cmd_valid !== 1'b0 || err_valid !== 1'b0 || bank_open !== 16'h0004) begin bad++;
      $display("FAIL des_cs valid=%b err=%b open=%h exp=0/0/0004", cmd_valid, err_valid, bank_open); end
    act(4'h6, 17'h4);
    cke = 1'b0;
    tick();
    total++; if (cmd_valid !== 1'b0 || err_valid !== 1'b0 || bank_open !== 16'h0004) begin bad++;
      $display("FAIL des_cke valid=%b err=%b open=%h exp=0/0/0004", cmd_valid, err_valid, bank_open); end
    act(4'h7, 17'h4);
    tick();
    total++; if (cmd_valid !== 1'b1 || bank_busy !== 16'h0080) begin bad++;
      $display("FAIL act_b7 valid=%b busy=%h exp=1/0080", cmd_valid, bank_busy); end
    rst = 1'b1;
    des();
    tick();
    total++; if (cmd_valid !== 1'b0 || bank_open !== 16'h0 || bank_busy !== 16'h0 || dbg_bank_state !== 32'h0) begin bad++;
      $display("FAIL rst_mid valid=%b open=%h busy=%h st=%h exp=0", cmd_valid, bank_open, bank_busy, dbg_bank_state); end
    rst = 1'b0;
    act(4'h7, 17'h4);
    tick();
    total++; if (cmd_valid !== 1'b1 || dbg_bank_state[15:14] !== 2'd1) begin bad++;
      $display("FAIL post_rst_act valid=%b st=%0d exp=1/1", cmd_valid, dbg_bank_state[15:14]); end
    des();
    tick();
  endtask

  task automatic test_parity();
    drive(1'b0, 1'b0, 17'h3, 4'h0, 1'b1);
    tick();
`ifdef DDR4_CA_PARITY_EN
    total++; if (err_valid !== 1'b1 || err_code !== 2'd3 || cmd_valid !== 1'b0) begin bad++;
      $display("FAIL parity_err err=%b code=%0d valid=%b exp=1/3/0", err_valid, err_code, cmd_valid); end
    total++; if (bank_open[0] !== 1'b0) begin bad++;
      $display("FAIL parity_nochange open0=%b exp=0", bank_open[0]); end
`else
    total++; if (cmd_valid !== 1'b1 || err_valid !== 1'b0 || bank_open[0] !== 1'b1) begin bad++;
      $display("FAIL parity_ignored valid=%b err=%b open0=%b exp=1/0/1", cmd_valid, err_valid, bank_open[0]); end
`endif
    des();
    tick();
  endtask

  // sequence and final report
  initial begin
    rst = 1'b1;
    des();
    test_reset();
    test_act_all();
    test_prea();
    test_rd_timing();
    test_back_to_back();
    test_ref();
    test_misc();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
